// File: rtl/wb_sram_bridge.sv
// Wishbone pipelined slave driving an external asynchronous SRAM with registered strobes.
// Optional write-protect window enabled by defining WB_SRAM_BRIDGE_WP_EN (adds wp_i).
module wb_sram_bridge #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 17,
  parameter int unsigned           WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] WP_BASE     = 17'h1_8000
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_n_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  wb_we_i,
  input  logic                  wb_cycle_i,
  input  logic                  wb_strobe_i,
  output logic                  wb_stall_o,
  output logic                  wb_ack_o,
`ifdef WB_SRAM_BRIDGE_WP_EN
  input  logic                  wp_i,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_data_oe_o,
  output logic                  ram_oe_n_o,
  output logic                  ram_we_n_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRd      = 3'd1;
  localparam logic [2:0] StWrSetup = 3'd2;
  localparam logic [2:0] StWrPulse = 3'd3;
  localparam logic [2:0] StWrHold  = 3'd4;
  localparam logic [2:0] StAck     = 3'd5;

  localparam logic [3:0] WaitCnt = WAIT_STATES[3:0];

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [2:0]            w_done_state;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  r_abort;
  logic                  w_abort_nxt;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_we_allow;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_data_oe;

  assign w_stall  = !((r_state == StIdle) || (r_state == StAck));
  assign w_accept = wb_cycle_i & wb_strobe_i & ~w_stall;

`ifdef WB_SRAM_BRIDGE_WP_EN
  logic r_wp_blk;

  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_n_i) begin
      r_wp_blk <= 1'b0;
    end else if (w_accept) begin
      r_wp_blk <= wp_i & wb_we_i & (wb_addr_i >= WP_BASE);
    end
  end

  assign w_we_allow = ~r_wp_blk;
`else
  assign w_we_allow = 1'b1;
`endif

  // An abort seen at any point of the access suppresses the ack at the end.
  assign w_done_state = (r_abort | ~wb_cycle_i) ? StIdle : StAck;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = r_abort | ~wb_cycle_i;
    w_capture   = 1'b0;
    case (r_state)
      StIdle, StAck: begin
        w_state_nxt = StIdle;
        w_abort_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt = wb_we_i ? StWrSetup : StRd;
          w_cnt_nxt   = WaitCnt;
        end
      end
      StRd: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = w_done_state;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      StWrSetup: begin
        w_state_nxt = StWrPulse;
        w_cnt_nxt   = WaitCnt;
      end
      StWrPulse: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StWrHold;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      StWrHold: w_state_nxt = w_done_state;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // SRAM strobes are registered from the next state so they never glitch.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_n_i) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_abort   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_abort   <= w_abort_nxt;
      if (w_accept) begin
        r_addr  <= wb_addr_i;
        r_wdata <= wb_data_i;
      end
      if (w_capture) begin
        r_rdata <= ram_data_i;
      end
      r_oe_n    <= (w_state_nxt != StRd);
      r_we_n    <= !((w_state_nxt == StWrPulse) && w_we_allow);
      r_data_oe <= (w_state_nxt == StWrSetup) || (w_state_nxt == StWrPulse) ||
                   (w_state_nxt == StWrHold);
    end
  end

  assign wb_stall_o    = w_stall;
  assign wb_ack_o      = (r_state == StAck);
  assign wb_data_o     = r_rdata;
  assign ram_addr_o    = r_addr;
  assign ram_data_o    = r_wdata;
  assign ram_data_oe_o = r_data_oe;
  assign ram_oe_n_o    = r_oe_n;
  assign ram_we_n_o    = r_we_n;

endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
- Synthesizable Wishbone (pipelined-mode) slave that sits directly downstream of the Wishbone master and its bench driver.
- Converts each accepted Wishbone request into one timed access on the board's external asynchronous SRAM.
- Applies the required setup, wait-state and hold timing.
- Returns read data and a single-cycle ack.
- Handles one request at a time and uses stall to apply back-pressure.

Parameters:
- DATA_WIDTH, 8: width of the Wishbone and SRAM data buses.
- ADDR_WIDTH, 17: width of the Wishbone and SRAM address buses (128 KiB).
- WAIT_STATES, 2: extra cycles the SRAM strobe is held beyond the first. Legal range is 0..15.
- WP_BASE, 17'h1_8000: lowest write-protected address. Used only with WB_SRAM_BRIDGE_WP_EN.

Ports:
- wb_clock_i, in, 1: the single clock.
- wb_reset_n_i, in, 1: reset, synchronous, active-low.
- wb_addr_i, in, ADDR_WIDTH: request address.
- wb_data_i, in, DATA_WIDTH: write data.
- wb_data_o, out, DATA_WIDTH: read data, valid while wb_ack_o is high.
- wb_we_i, in, 1: 1 = write, 0 = read.
- wb_cycle_i, in, 1: bus cycle active.
- wb_strobe_i, in, 1: request valid.
- wb_stall_o, out, 1: slave cannot accept a request this cycle.
- wb_ack_o, out, 1: one-cycle completion pulse.
- ram_addr_o, out, ADDR_WIDTH: SRAM address.
- ram_data_i, in, DATA_WIDTH: SRAM read data.
- ram_data_o, out, DATA_WIDTH: SRAM write data.
- ram_data_oe_o, out, 1: 1 = FPGA drives the SRAM data pins.
- ram_oe_n_o, out, 1: SRAM output enable, active-low.
- ram_we_n_o, out, 1: SRAM write enable, active-low.

Behaviour:
- Reset (wb_reset_n_i low at a clock edge):
  - After that edge: state IDLE; wb_stall_o=0, wb_ack_o=0, wb_data_o=0.
  - ram_oe_n_o=1, ram_we_n_o=1, ram_data_oe_o=0; ram_addr_o and ram_data_o are 0.
  - Reset wins over everything, including mid-access. An in-progress write pulse is cut short; no ack is issued.
- Accept: a request is accepted at an edge where wb_cycle_i & wb_strobe_i & !wb_stall_o. At acceptance, address, data and we are latched; the SRAM outputs are driven only from these latched values.
- Stall: wb_stall_o is 1 in every state except IDLE and ACK.
- Read, states IDLE -> RD -> ACK:
  - RD lasts WAIT_STATES+1 cycles, counted by a 4-bit down-counter.
  - In RD: ram_oe_n_o=0.
  - ram_data_i is registered into wb_data_o at the last RD edge.
  - Ack rises WAIT_STATES+2 edges after the acceptance edge.
- Write, states IDLE -> WR_SETUP (1 cycle) -> WR_PULSE (WAIT_STATES+1 cycles) -> WR_HOLD (1 cycle) -> ACK:
  - ram_data_oe_o=1 in WR_SETUP, WR_PULSE and WR_HOLD.
  - ram_we_n_o=0 only in WR_PULSE.
  - Ack rises WAIT_STATES+4 edges after acceptance.
- Glitch-free strobes: ram_oe_n_o and ram_we_n_o are registered, and are never low together.
- ACK: lasts exactly 1 cycle with wb_ack_o=1.
  - wb_stall_o=0 in ACK, so a new request can be accepted on the ACK edge (back-to-back).
  - Otherwise the next state is IDLE.
  - wb_data_o holds its value until the next read capture.
- Abort: wb_cycle_i low during RD or WR_*.
  - The SRAM sequence still runs to completion, so the write pulse is never truncated.
  - ACK is replaced by a return to IDLE with wb_ack_o=0.
- No-op inputs: strobe without cycle is ignored. Requests arriving while stalled are not latched, and the master must hold them.

Optional Feature:
- Macro: WB_SRAM_BRIDGE_WP_EN.
- When defined:
  - Adds input port wp_i (1 bit).
  - A write accepted with wp_i=1 and latched address >= WP_BASE runs the normal write sequence and timing, including ack, but ram_we_n_o stays 1 throughout. This emulates PET ROM regions held in SRAM.
- When undefined: no wp_i port, WP_BASE is ignored, and all writes reach the SRAM.

Test Plan:
- Reset: hold wb_reset_n_i=0 for 2 edges during a write pulse -> ram_we_n_o=1 and wb_ack_o=0 after the first edge; all outputs at their reset values; a subsequent read works.
- Read, WAIT_STATES=2: SRAM model returns 8'hA5 at 17'h00123 -> ram_oe_n_o low for 3 cycles; wb_ack_o high for exactly 1 cycle, 4 edges after acceptance; wb_data_o=8'hA5; stall high for 3 cycles.
- Write 8'h3C to 17'h0FFFF -> address stable for 5 cycles; we_n low for exactly 3 cycles; data driven 1 cycle before and after; ack 6 edges after acceptance; read-back gives 8'h3C.
- Back-to-back: master raises strobe for a second read in the ACK cycle -> accepted on the ACK edge; second ack 4 edges later; no IDLE bubble.
- Abort: drop wb_cycle_i in the 2nd WR_PULSE cycle -> we_n pulse still 3 cycles; no ack; next request accepted normally.
- WP (macro defined): wp_i=1, write 8'hFF to 17'h1_8000 -> ack arrives on time, ram_we_n_o never low, memory unchanged. The same write to 17'h1_7FFF is performed.
